// File: rtl/rd_fifo_stream_adapter_pkg.sv
// Shared constants and elaboration helpers for the FIFO read-port stream adapter.
package rd_fifo_stream_adapter_pkg;

  localparam int C_RD_LATENCY_DFLT = 1;
  localparam int C_BUF_DEPTH_DFLT  = 4;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int p = 1; p < v; p = p * 2) r++;
    return r;
  endfunction

  function automatic bit rd_latency_ok(input int lat);
    return (lat == 1) || (lat == 2);
  endfunction

  // A single-entry buffer would leave zero-width pointers.
  function automatic bit buf_depth_ok(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

  localparam int BUF_AW = clog2(C_BUF_DEPTH_DFLT);

endpackage

// File: rtl/rd_fifo_stream_skidbuf.sv
// Register-based circular buffer: write at wr_ptr, FWFT read at rd_ptr, level count.
module rd_fifo_stream_skidbuf
  import rd_fifo_stream_adapter_pkg::*;
#(
  parameter int c_DATA_WIDTH = 32,
  parameter int c_AW         = BUF_AW
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clr_i,
  input  logic                    wr_en_i,
  input  logic [c_DATA_WIDTH-1:0] wr_data_i,
  input  logic                    pop_i,
  output logic [c_DATA_WIDTH-1:0] rd_data_o,
  output logic [c_AW:0]           level_o
);

  localparam int DEPTH = 1 << c_AW;

  logic [DEPTH-1:0][c_DATA_WIDTH-1:0] mem_q;
  logic [c_AW-1:0]                    wr_ptr_q, rd_ptr_q;
  logic [c_AW:0]                      level_q, level_d;
  logic                               do_pop;

  assign do_pop  = pop_i && (level_q != '0);
  assign level_d = level_q + {{c_AW{1'b0}}, wr_en_i} - {{c_AW{1'b0}}, do_pop};

  // Clear wins over a same-cycle capture or pop.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (wr_en_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                  mem_q           <= '0;
    else if (wr_en_i && !clr_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign level_o   = level_q;

endmodule

// File: rtl/rd_fifo_stream_adapter.sv
// Converts the FIFO's fixed-latency read port into a bubble-free valid/ready stream
// using credit-based issue into a small skid buffer.
module rd_fifo_stream_adapter
  import rd_fifo_stream_adapter_pkg::*;
#(
  parameter int c_DATA_WIDTH = 32,
  parameter int c_RD_LATENCY = C_RD_LATENCY_DFLT,
  parameter int c_BUF_DEPTH  = C_BUF_DEPTH_DFLT
) (
  input  logic                          rd_clk,
  input  logic                          rd_rst,
  input  logic [c_DATA_WIDTH-1:0]       fifo_rd_data,
  input  logic                          fifo_rd_empty,
  output logic                          fifo_rd_en,
  output logic                          fifo_rd_oce,
  input  logic                          flush,
  output logic [c_DATA_WIDTH-1:0]       m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [clog2(c_BUF_DEPTH):0]   buf_level
);

  localparam int AW    = clog2(c_BUF_DEPTH);
  localparam int LVL_W = AW + 1;

  generate
    if (!rd_latency_ok(c_RD_LATENCY)) begin : g_bad_lat
      $error("c_RD_LATENCY must be 1 or 2");
    end
    if (!buf_depth_ok(c_BUF_DEPTH)) begin : g_bad_depth
      $error("c_BUF_DEPTH must be a power of two >= 2");
    end
  endgenerate

  logic [c_RD_LATENCY-1:0] inflight_q, inflight_d;
  logic [LVL_W-1:0]        inflight_cnt, credit_used;
  logic                    issue, capture;

  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < c_RD_LATENCY; i++)
      inflight_cnt = inflight_cnt + {{(LVL_W-1){1'b0}}, inflight_q[i]};
  end

  // Every outstanding read already owns a slot, so level+inflight never exceeds depth.
  assign credit_used = buf_level + inflight_cnt;
  assign issue       = !rd_rst && !fifo_rd_empty && !flush &&
                       (credit_used < LVL_W'(c_BUF_DEPTH));

  generate
    if (c_RD_LATENCY == 1) begin : g_lat1
      assign inflight_d = issue;
    end else begin : g_latn
      assign inflight_d = {inflight_q[c_RD_LATENCY-2:0], issue};
    end
  endgenerate

  // Clearing the strobes on flush drops words still on their way back.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst)     inflight_q <= '0;
    else if (flush) inflight_q <= '0;
    else            inflight_q <= inflight_d;
  end

  assign capture = inflight_q[c_RD_LATENCY-1];

  rd_fifo_stream_skidbuf #(
    .c_DATA_WIDTH (c_DATA_WIDTH),
    .c_AW         (AW)
  ) u_skidbuf (
    .clk_i     (rd_clk),
    .rst_i     (rd_rst),
    .clr_i     (flush),
    .wr_en_i   (capture),
    .wr_data_i (fifo_rd_data),
    .pop_i     (m_ready),
    .rd_data_o (m_data),
    .level_o   (buf_level)
  );

  assign fifo_rd_en  = issue;
  assign fifo_rd_oce = 1'b1;
  assign m_valid     = (buf_level != '0);

endmodule
